// File: rtl/agc_instr_decode.sv
// rtl/agc_instr_decode.sv - AGC instruction word decoder with EXTEND prefix and optional INDEX handling
// Optional feature macro: AGC_INDEX_EN (INDEX instruction support and index register).
module agc_instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [14:0] instr,
    output logic        instr_ready,
    input  logic        index_valid,
    input  logic [14:0] index_value,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [2:0]  opcode,
    output logic [1:0]  qc,
    output logic [11:0] addr12,
    output logic [9:0]  addr10,
    output logic        extracode,
    output logic        indexed,
    output logic        index_req
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOLD       = 2'd1,
        WAIT_INDEX = 2'd2
    } state_t;

    localparam logic [14:0] EXTEND_WORD = 15'o00006;

    state_t      state_q, state_d;
    logic        dec_valid_q, dec_valid_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [1:0]  qc_q, qc_d;
    logic [11:0] addr12_q, addr12_d;
    logic [9:0]  addr10_q, addr10_d;
    logic        extracode_q, extracode_d;
    logic        ext_flag_q, ext_flag_d;

    logic        accept;
    logic        is_ext;
    logic        is_index;
    logic        word_indexed;
    logic [14:0] eff_word;

`ifdef AGC_INDEX_EN
    logic        indexed_q, indexed_d;
    logic        index_req_q, index_req_d;
    logic        idx_pend_q, idx_pend_d;
    logic [14:0] idx_reg_q, idx_reg_d;
`else
    logic        unused_index;
    assign unused_index = ^{index_valid, index_value};
`endif

    assign instr_ready = (state_q == IDLE) || ((state_q == HOLD) && dec_ready);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d     = state_q;
        dec_valid_d = dec_valid_q;
        opcode_d    = opcode_q;
        qc_d        = qc_q;
        addr12_d    = addr12_q;
        addr10_d    = addr10_q;
        extracode_d = extracode_q;
        ext_flag_d  = ext_flag_q;

        eff_word     = instr;
        is_ext       = (instr == EXTEND_WORD);
        is_index     = 1'b0;
        word_indexed = 1'b0;

`ifdef AGC_INDEX_EN
        indexed_d   = indexed_q;
        index_req_d = index_req_q;
        idx_pend_d  = idx_pend_q;
        idx_reg_d   = idx_reg_q;

        // A pending index turns the next word into a plain indexed decode.
        if (idx_pend_q) begin
            eff_word     = instr + idx_reg_q;
            is_ext       = 1'b0;
            word_indexed = 1'b1;
        end else begin
            is_index = (instr[14:12] == 3'b101) && (instr[11:10] == 2'b00);
        end
`endif

        case (state_q)
            HOLD: begin
                if (dec_ready) begin
                    dec_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            WAIT_INDEX: begin
`ifdef AGC_INDEX_EN
                if (index_valid) begin
                    idx_reg_d   = index_value;
                    idx_pend_d  = 1'b1;
                    index_req_d = 1'b0;
                    state_d     = IDLE;
                end
`endif
            end
            default: ;
        endcase

        if (accept) begin
            if (is_ext) begin
                ext_flag_d  = 1'b1;
                dec_valid_d = 1'b0;
                state_d     = IDLE;
            end else if (is_index) begin
                dec_valid_d = 1'b0;
                state_d     = WAIT_INDEX;
`ifdef AGC_INDEX_EN
                index_req_d = 1'b1;
`endif
            end else begin
                dec_valid_d = 1'b1;
                state_d     = HOLD;
                opcode_d    = eff_word[14:12];
                qc_d        = eff_word[11:10];
                addr12_d    = eff_word[11:0];
                addr10_d    = eff_word[9:0];
                extracode_d = ext_flag_q;
                ext_flag_d  = 1'b0;
`ifdef AGC_INDEX_EN
                indexed_d   = word_indexed;
                idx_pend_d  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dec_valid_q <= 1'b0;
            opcode_q    <= '0;
            qc_q        <= '0;
            addr12_q    <= '0;
            addr10_q    <= '0;
            extracode_q <= 1'b0;
            ext_flag_q  <= 1'b0;
`ifdef AGC_INDEX_EN
            indexed_q   <= 1'b0;
            index_req_q <= 1'b0;
            idx_pend_q  <= 1'b0;
            idx_reg_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dec_valid_q <= dec_valid_d;
            opcode_q    <= opcode_d;
            qc_q        <= qc_d;
            addr12_q    <= addr12_d;
            addr10_q    <= addr10_d;
            extracode_q <= extracode_d;
            ext_flag_q  <= ext_flag_d;
`ifdef AGC_INDEX_EN
            indexed_q   <= indexed_d;
            index_req_q <= index_req_d;
            idx_pend_q  <= idx_pend_d;
            idx_reg_q   <= idx_reg_d;
`endif
        end
    end

    assign dec_valid = dec_valid_q;
    assign opcode    = opcode_q;
    assign qc        = qc_q;
    assign addr12    = addr12_q;
    assign addr10    = addr10_q;
    assign extracode = extracode_q;
`ifdef AGC_INDEX_EN
    assign indexed   = indexed_q;
    assign index_req = index_req_q;
`else
    assign indexed   = 1'b0;
    assign index_req = 1'b0;
`endif

endmodule

// File: tb/tb_agc_instr_decode.sv
// tb/tb_agc_instr_decode.sv - scoreboard bench for agc_instr_decode
module tb_agc_instr_decode;

`ifdef AGC_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [14:0] instr = '0;
    logic        instr_ready;
    logic        index_valid = 1'b0;
    logic [14:0] index_value = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic [11:0] addr12;
    logic [9:0]  addr10;
    logic        extracode;
    logic        indexed;
    logic        index_req;

    agc_instr_decode dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .index_valid (index_valid),
        .index_value (index_value),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .opcode      (opcode),
        .qc          (qc),
        .addr12      (addr12),
        .addr10      (addr10),
        .extracode   (extracode),
        .indexed     (indexed),
        .index_req   (index_req)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [28:0] sb[$];
    logic [28:0] exp_f;
    bit          m_ext = 1'b0;
    bit          m_pend = 1'b0;
    logic [14:0] m_idx = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] fields(input logic [14:0] w, input bit e, input bit ix);
        return {w[14:12], w[11:10], w[11:0], w[9:0], e, ix};
    endfunction

    // Reference behaviour applied at the moment a word is accepted.
    task automatic model_accept(input logic [14:0] w);
        logic [14:0] eff;
        if (IDX_EN && m_pend) begin
            eff = w + m_idx;
            sb.push_back(fields(eff, m_ext, 1'b1));
            m_ext  = 1'b0;
            m_pend = 1'b0;
        end else if (w == 15'o00006) begin
            m_ext = 1'b1;
        end else if (IDX_EN && w[14:10] == 5'b10100) begin
            m_ext = m_ext;
        end else begin
            sb.push_back(fields(w, m_ext, 1'b0));
            m_ext = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [14:0] w);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr       = w;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check_eq("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        model_accept(w);
    endtask

    task automatic give_index(input logic [14:0] v);
        index_valid = 1'b1;
        index_value = v;
        @(posedge clk);
        #1;
        index_valid = 1'b0;
        m_idx  = v;
        m_pend = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && dec_valid && dec_ready) begin
            if (sb.size() == 0) begin
                check_eq("extra_decode", 32'd1, 32'd0);
            end else begin
                exp_f = sb.pop_front();
                check_eq("decode", {3'd0, opcode, qc, addr12, addr10, extracode, indexed}, {3'd0, exp_f});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check_eq("rst_index_req", {31'd0, index_req}, 32'd0);
        check_eq("rst_fields", {3'd0, opcode, qc, addr12, addr10, extracode, indexed}, 32'd0);
        check_eq("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        next_cycle();

        // Plain decode
        send(15'o30100);
        @(negedge clk);
        check_eq("plain_dec_valid", {31'd0, dec_valid}, 32'd1);
        check_eq("plain_opcode", {29'd0, opcode}, 32'd3);
        check_eq("plain_addr12", {20'd0, addr12}, 32'o0100);
        next_cycle();

        // EXTEND prefix, then cleared by next decode
        send(15'o00006);
        @(negedge clk);
        check_eq("extend_no_decode", {31'd0, dec_valid}, 32'd0);
        next_cycle();
        send(15'o70200);
        send(15'o70200);
        send(15'o00006);
        send(15'o00006);
        send(15'o10000);
        next_cycle();

        // Back-pressure: three stalled cycles, then back-to-back accept
        dec_ready = 1'b0;
        send(15'o20123);
        instr_valid = 1'b1;
        instr       = 15'o41234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_instr_ready", {31'd0, instr_ready}, 32'd0);
            check_eq("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
            check_eq("stall_addr12", {20'd0, addr12}, 32'o0123);
        end
        next_cycle();
        dec_ready = 1'b1;
        send(15'o41234);
        @(negedge clk);
        check_eq("b2b_no_bubble", {31'd0, dec_valid}, 32'd1);
        next_cycle();
        for (int i = 0; i < 6; i++) send(15'($urandom_range(32'h0008, 32'h27FF)));
        next_cycle();

`ifdef AGC_INDEX_EN
        // index_valid outside WAIT_INDEX must be ignored
        give_index(15'o00007);
        m_pend = 1'b0;
        send(15'o30100);
        next_cycle();

        send(15'o50040);
        @(negedge clk);
        check_eq("idx_req_set", {31'd0, index_req}, 32'd1);
        check_eq("idx_instr_ready", {31'd0, instr_ready}, 32'd0);
        check_eq("idx_no_decode", {31'd0, dec_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("idx_req_held", {31'd0, index_req}, 32'd1);
        next_cycle();
        give_index(15'o00005);
        @(negedge clk);
        check_eq("idx_req_clear", {31'd0, index_req}, 32'd0);
        next_cycle();
        send(15'o00100);
        @(negedge clk);
        check_eq("idx_addr12", {20'd0, addr12}, 32'o0105);
        check_eq("idx_indexed", {31'd0, indexed}, 32'd1);
        next_cycle();

        // Indexed result equal to EXTEND is still decoded
        send(15'o50040);
        next_cycle();
        give_index(15'o00005);
        send(15'o00001);
        next_cycle();

        // EXTEND survives an INDEX; sum wraps modulo 2^15
        send(15'o00006);
        send(15'o50040);
        next_cycle();
        give_index(15'o10003);
        send(15'o70000);
        next_cycle();

        // Reset abandons WAIT_INDEX
        send(15'o50040);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset  = 1'b0;
        m_ext  = 1'b0;
        m_pend = 1'b0;
        @(negedge clk);
        check_eq("rst_wait_index_req", {31'd0, index_req}, 32'd0);
        check_eq("rst_wait_ready", {31'd0, instr_ready}, 32'd1);
        next_cycle();
        send(15'o30100);
        @(negedge clk);
        check_eq("rst_wait_unindexed", {31'd0, indexed}, 32'd0);
        next_cycle();
`else
        send(15'o50040);
        @(negedge clk);
        check_eq("noidx_dec_valid", {31'd0, dec_valid}, 32'd1);
        check_eq("noidx_opcode", {29'd0, opcode}, 32'd5);
        check_eq("noidx_index_req", {31'd0, index_req}, 32'd0);
        next_cycle();
`endif

        repeat (3) next_cycle();
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/agc_instr_decode.md
AGC_INSTR_DECODE -- requirements
Module: agc_instr_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port instr_valid, input, 1 bit: a 15-bit instruction word from memory is present on instr.
REQ-004 SHALL have port instr, input, 15 bits: raw instruction word; bits 14:12 opcode, 11:10 QC, 11:0 addr12, 9:0 addr10.
REQ-005 SHALL have port instr_ready, output, 1 bit: the block accepts instr this cycle.
REQ-006 SHALL have port index_valid, input, 1 bit: index_value is present for a pending INDEX.
REQ-007 SHALL have port index_value, input, 15 bits: operand fetched by the control unit for INDEX.
REQ-008 SHALL have port dec_valid, output, 1 bit: the decoded fields are valid.
REQ-009 SHALL have port dec_ready, input, 1 bit: the control unit consumes the decoded fields this cycle.
REQ-010 SHALL have output ports opcode (3 bits), qc (2 bits), addr12 (12 bits) and addr10 (10 bits): the decoded fields.
REQ-011 SHALL have output ports extracode (1 bit) and indexed (1 bit): flags qualifying the decoded word.
REQ-012 SHALL have port index_req, output, 1 bit: an INDEX is waiting for index_value.

Function
REQ-013 SHALL accept a word when instr_valid and instr_ready are both high ("accept").
REQ-014 SHALL drive instr_ready high in IDLE, high in HOLD when dec_ready is high, and low in WAIT_INDEX.
REQ-015 SHALL implement states IDLE, HOLD and WAIT_INDEX; reset enters IDLE.
REQ-016 SHALL treat a raw word equal to 15'o00006 as EXTEND: on accept, set the internal extracode flag, produce no decoded output, and go to IDLE.
REQ-017 SHALL treat a raw word with opcode 3'b101 and QC 2'b00 as INDEX: on accept, go to WAIT_INDEX with index_req high, produce no decoded output, and keep the extracode flag unchanged.
REQ-018 SHALL, in WAIT_INDEX when index_valid is high, latch index_value, set the index-pending flag, clear index_req, and go to IDLE the next cycle.
REQ-019 SHALL decode any other accepted word on the next cycle: go to HOLD, raise dec_valid, and register the fields taken from the effective word.
REQ-020 SHALL form the effective word as the raw word when no index is pending, or as (raw + latched index) mod 2^15 when an index is pending.
REQ-021 SHALL never treat an indexed effective word as EXTEND or INDEX; it is always decoded, with indexed set to 1.
REQ-022 SHALL drive extracode with the flag value at accept, then clear both the extracode flag and the index-pending flag on that accept.
REQ-023 SHALL hold all decoded outputs stable while dec_valid is high and dec_ready is low.
REQ-024 SHALL drop dec_valid the cycle after dec_valid and dec_ready are both high, unless a new word is accepted in the same cycle.
REQ-025 SHALL, on back-to-back accept in HOLD, produce the new decode with no bubble cycle.
REQ-026 SHALL, on consecutive EXTEND words, leave extracode set (idempotent).
REQ-027 SHALL ignore index_valid outside WAIT_INDEX.

Reset
REQ-028 SHALL, on reset high at a clock edge, clear dec_valid, index_req, opcode, qc, addr12, addr10, extracode and indexed to 0, clear the internal flags and index register to 0, and go to IDLE.
REQ-029 SHALL give reset priority over every simultaneous event; an in-flight HOLD or WAIT_INDEX is abandoned without output.

Configuration
REQ-030 SHALL compile INDEX handling (REQ-017, REQ-018, REQ-020, REQ-021, index register) only when macro AGC_INDEX_EN is defined.
REQ-031 SHALL, when AGC_INDEX_EN is undefined, decode INDEX words as ordinary instructions, tie index_req and indexed to 0, and ignore index_valid/index_value.

Verification
REQ-032 SHALL verify: accept 15'o30100 with dec_ready=1 -> next cycle dec_valid=1, opcode=3, qc=0, addr12=12'o0100, extracode=0, indexed=0.
REQ-033 SHALL verify: EXTEND then 15'o70200 -> only one decode, opcode=7, extracode=1; following 15'o70200 -> extracode=0.
REQ-034 SHALL verify: INDEX 15'o50040, index_value=15'o00005, then 15'o00100 -> index_req high until index_valid, decode addr12=12'o0105, indexed=1.
REQ-035 SHALL verify: dec_ready held low 3 cycles with instr_valid high -> instr_ready low, outputs stable, one decode delivered.
REQ-036 SHALL verify: reset asserted in WAIT_INDEX -> next cycle IDLE, index_req=0, following word decoded unindexed.
REQ-037 SHALL verify: build without AGC_INDEX_EN, accept 15'o50040 -> dec_valid=1, opcode=5, qc=0, index_req=0.
